// File: rtl/lc3_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// lc3_mem_arbiter_if
// Bundles the three buses around the LC-3 memory arbiter: the CPU requester
// (MAR/MDR path), the debug/loader requester and the single-port memory.
// The arbiter connects through the "slave" modport; the surrounding system
// (CPU control, loader, memory array) uses the "master" modport.
// ---------------------------------------------------------------------------
interface lc3_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // CPU requester
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    // Debug / loader requester
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    // Memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lc3_mem_arbiter
// Sequences the single-port unified LC-3 memory and shares it between the CPU
// memory interface and the debug/loader port. Every access runs
// IDLE -> ACCESS -> WAIT -> RESP; the completion pulse to the CPU is the
// LC-3 ready signal R (cpu_ack). All outputs come straight from flops.
//
// Optional build macro LC3_MEM_ARB_ROUNDROBIN_EN:
//   defined   - round-robin arbitration with a 1-bit preferred-requester
//               pointer (resets to CPU, flips after every grant)
//   undefined - fixed priority, the CPU always wins a tie
// ---------------------------------------------------------------------------
module lc3_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1    // legal range 1..15
) (
    input  logic               clk,
    input  logic               reset_n,
    lc3_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // WAIT countdown start value; cnt reaching zero marks the rdata cycle
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t            state_q,     state_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cpu_ack_q,   cpu_ack_d;
    logic              dbg_ack_q,   dbg_ack_d;
    logic              busy_q,      busy_d;
    logic              owner_q,     owner_d;
`ifdef LC3_MEM_ARB_ROUNDROBIN_EN
    logic              rr_ptr_q,    rr_ptr_d;   // 0 = CPU preferred, 1 = debug
`endif

    logic              any_req_s;
    logic              grant_dbg_s;

    // Arbitration: decide which requester would be granted in IDLE this cycle
    always_comb begin
        any_req_s   = bus.cpu_req | bus.dbg_req;
        grant_dbg_s = 1'b0;
`ifdef LC3_MEM_ARB_ROUNDROBIN_EN
        if (bus.cpu_req && bus.dbg_req) begin
            grant_dbg_s = rr_ptr_q;
        end else if (bus.dbg_req) begin
            grant_dbg_s = 1'b1;
        end else begin
            grant_dbg_s = 1'b0;
        end
`else
        if (bus.cpu_req) begin
            grant_dbg_s = 1'b0;
        end else if (bus.dbg_req) begin
            grant_dbg_s = 1'b1;
        end else begin
            grant_dbg_s = 1'b0;
        end
`endif
    end

    // Next-state and next-output logic of the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        owner_d     = owner_q;
`ifdef LC3_MEM_ARB_ROUNDROBIN_EN
        rr_ptr_d    = rr_ptr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    // Latch the winner's command; the strobe is issued next cycle
                    owner_d     = grant_dbg_s;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_dbg_s ? bus.dbg_we    : bus.cpu_we;
                    mem_addr_d  = grant_dbg_s ? bus.dbg_addr  : bus.cpu_addr;
                    mem_wdata_d = grant_dbg_s ? bus.dbg_wdata : bus.cpu_wdata;
`ifdef LC3_MEM_ARB_ROUNDROBIN_EN
                    rr_ptr_d    = ~grant_dbg_s;
`endif
                    state_d     = ST_ACCESS;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_WAIT;
                end else begin
                    // mem_rdata is valid now; writes leave the rdata registers alone
                    if (!mem_we_q) begin
                        if (owner_q) begin
                            dbg_rdata_d = bus.mem_rdata;
                        end else begin
                            cpu_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                    if (owner_q) begin
                        dbg_ack_d = 1'b1;
                    end else begin
                        cpu_ack_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
`ifdef LC3_MEM_ARB_ROUNDROBIN_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
`ifdef LC3_MEM_ARB_ROUNDROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_arbiter
// Three arbiter instances with MEM_LATENCY 1, 4 and 3, each behind its own
// latency-accurate memory model (read data is only driven in the exact
// cycle it is due). Expected transactions are queued when stimulus is
// issued and checked against every ack the arbiters produce.
// ---------------------------------------------------------------------------
module tb_lc3_mem_arbiter;

    localparam int NI = 3;

    typedef struct packed {
        logic        port;   // 0 = CPU, 1 = debug
        logic        we;
        logic [15:0] data;
    } txn_t;

    logic        clk;
    logic        rst_n     [NI];
    logic        cpu_req   [NI];
    logic        cpu_we    [NI];
    logic [15:0] cpu_addr  [NI];
    logic [15:0] cpu_wdata [NI];
    logic [15:0] cpu_rdata [NI];
    logic        cpu_ack   [NI];
    logic        dbg_req   [NI];
    logic        dbg_we    [NI];
    logic [15:0] dbg_addr  [NI];
    logic [15:0] dbg_wdata [NI];
    logic [15:0] dbg_rdata [NI];
    logic        dbg_ack   [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [15:0] mem_addr  [NI];
    logic [15:0] mem_wdata [NI];
    logic        busy      [NI];
    logic        owner     [NI];

    txn_t        exp_q     [NI][$];
    logic [15:0] ref_mem   [NI][256];
    logic        ptr_model [NI];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 4 : 3);

        lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

        logic        rn;
        logic [15:0] marr [256];
        logic [3:0]  mcnt;
        logic [15:0] mdat;

        assign rn            = rst_n[g];
        assign bus.cpu_req   = cpu_req[g];
        assign bus.cpu_we    = cpu_we[g];
        assign bus.cpu_addr  = cpu_addr[g];
        assign bus.cpu_wdata = cpu_wdata[g];
        assign bus.dbg_req   = dbg_req[g];
        assign bus.dbg_we    = dbg_we[g];
        assign bus.dbg_addr  = dbg_addr[g];
        assign bus.dbg_wdata = dbg_wdata[g];
        assign cpu_rdata[g]  = bus.cpu_rdata;
        assign cpu_ack[g]    = bus.cpu_ack;
        assign dbg_rdata[g]  = bus.dbg_rdata;
        assign dbg_ack[g]    = bus.dbg_ack;
        assign mem_en[g]     = bus.mem_en;
        assign mem_we[g]     = bus.mem_we;
        assign mem_addr[g]   = bus.mem_addr;
        assign mem_wdata[g]  = bus.mem_wdata;
        assign busy[g]       = bus.busy;
        assign owner[g]      = bus.owner;

        lc3_mem_arbiter #(
            .ADDR_W      (16),
            .DATA_W      (16),
            .MEM_LATENCY (L)
        ) u_dut (
            .clk     (clk),
            .reset_n (rn),
            .bus     (bus.slave)
        );

        // Memory model: data for a read strobed in cycle c appears only in cycle c+L
        always @(posedge clk or negedge rn) begin
            if (!rn) begin
                mcnt <= 4'd0;
            end else if (bus.mem_en) begin
                mcnt <= 4'(L);
                mdat <= marr[bus.mem_addr[7:0]];
                if (bus.mem_we) marr[bus.mem_addr[7:0]] <= bus.mem_wdata;
            end else if (mcnt != 4'd0) begin
                mcnt <= mcnt - 4'd1;
            end
        end

        assign bus.mem_rdata = (mcnt == 4'd1) ? mdat : 16'hDEAD;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every ack is matched against the oldest expected transaction
    always @(negedge clk) begin
        txn_t e;
        for (int g = 0; g < NI; g++) begin
            if (rst_n[g] === 1'b1 && (cpu_ack[g] === 1'b1 || dbg_ack[g] === 1'b1)) begin
                check_val($sformatf("single_ack[%0d]", g), {31'd0, cpu_ack[g] & dbg_ack[g]}, 32'd0);
                if (exp_q[g].size() == 0) begin
                    check_val($sformatf("spurious_ack[%0d]", g), 32'd1, 32'd0);
                end else begin
                    e = exp_q[g].pop_front();
                    check_val($sformatf("ack_port[%0d]", g), {31'd0, dbg_ack[g]}, {31'd0, e.port});
                    check_val($sformatf("owner[%0d]", g), {31'd0, owner[g]}, {31'd0, e.port});
                    if (!e.we) begin
                        check_val($sformatf("rdata[%0d]", g),
                                  {16'd0, (e.port ? dbg_rdata[g] : cpu_rdata[g])}, {16'd0, e.data});
                    end
                end
            end
        end
    end

    task automatic push(input int g, input logic port, input logic we,
                        input logic [15:0] addr, input logic [15:0] wdata);
        txn_t t;
        t.port = port;
        t.we   = we;
        if (we) begin
            ref_mem[g][addr[7:0]] = wdata;
            t.data = wdata;
        end else begin
            t.data = ref_mem[g][addr[7:0]];
        end
        exp_q[g].push_back(t);
        ptr_model[g] = ~port;
    endtask

    task automatic set_req(input int g, input logic port, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata);
        if (port) begin
            dbg_we[g] = we; dbg_addr[g] = addr; dbg_wdata[g] = wdata; dbg_req[g] = 1'b1;
        end else begin
            cpu_we[g] = we; cpu_addr[g] = addr; cpu_wdata[g] = wdata; cpu_req[g] = 1'b1;
        end
    endtask

    // Hold a request until its ack, then release it at the start of the next cycle
    task automatic drive(input int g, input logic port, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        int   waited;
        logic got;
        waited = 0;
        got    = 1'b0;
        set_req(g, port, we, addr, wdata);
        while (!got && waited < 80) begin
            @(negedge clk);
            waited++;
            got = port ? (dbg_ack[g] === 1'b1) : (cpu_ack[g] === 1'b1);
        end
        check_val($sformatf("ack_seen[%0d]", g), {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        if (port) dbg_req[g] = 1'b0; else cpu_req[g] = 1'b0;
    endtask

    task automatic access(input int g, input logic port, input logic we,
                          input logic [15:0] addr, input logic [15:0] wdata);
        push(g, port, we, addr, wdata);
        drive(g, port, we, addr, wdata);
    endtask

    // Cycle-exact access: strobe at k=1, ack at k=L+2, busy from k=1 on
    task automatic timed(input int g, input logic port, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        int L;
        L = lat_of(g);
        push(g, port, we, addr, wdata);
        set_req(g, port, we, addr, wdata);
        for (int k = 0; k <= L + 2; k++) begin
            @(negedge clk);
            check_val($sformatf("mem_en[%0d] k=%0d", g, k), {31'd0, mem_en[g]}, {31'd0, (k == 1)});
            check_val($sformatf("own_ack[%0d] k=%0d", g, k),
                      {31'd0, (port ? dbg_ack[g] : cpu_ack[g])}, {31'd0, (k == L + 2)});
            check_val($sformatf("other_ack[%0d] k=%0d", g, k),
                      {31'd0, (port ? cpu_ack[g] : dbg_ack[g])}, 32'd0);
            check_val($sformatf("busy[%0d] k=%0d", g, k), {31'd0, busy[g]}, {31'd0, (k >= 1)});
            if (k == 1) begin
                check_val("mem_we", {31'd0, mem_we[g]}, {31'd0, we});
                check_val("mem_addr", {16'd0, mem_addr[g]}, {16'd0, addr});
                if (we) check_val("mem_wdata", {16'd0, mem_wdata[g]}, {16'd0, wdata});
            end
        end
        @(posedge clk); #1;
        if (port) dbg_req[g] = 1'b0; else cpu_req[g] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < NI; g++) begin
            check_val({tag, "_cpu_rdata"}, {16'd0, cpu_rdata[g]}, 32'd0);
            check_val({tag, "_dbg_rdata"}, {16'd0, dbg_rdata[g]}, 32'd0);
            check_val({tag, "_mem_addr"},  {16'd0, mem_addr[g]},  32'd0);
            check_val({tag, "_mem_wdata"}, {16'd0, mem_wdata[g]}, 32'd0);
            check_val({tag, "_flags"},
                      {22'd0, cpu_ack[g], dbg_ack[g], mem_en[g], mem_we[g], busy[g], owner[g], 4'd0},
                      32'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ci;
        int di;
        int acks;
        logic win;

        for (int g = 0; g < NI; g++) begin
            rst_n[g] = 1'b0;
            cpu_req[g] = 1'b0; cpu_we[g] = 1'b0; cpu_addr[g] = 16'h0000; cpu_wdata[g] = 16'h0000;
            dbg_req[g] = 1'b0; dbg_we[g] = 1'b0; dbg_addr[g] = 16'h0000; dbg_wdata[g] = 16'h0000;
            ptr_model[g] = 1'b0;
        end

        // Reset held two cycles, then ten idle cycles with no strobe
        @(negedge clk);
        check_all_zero("in_reset");
        @(posedge clk); @(posedge clk); #1;
        for (int g = 0; g < NI; g++) rst_n[g] = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) if (mem_en[g] === 1'b1 || busy[g] === 1'b1) acks++;
        end
        check_val("idle_activity", acks, 32'd0);
        check_all_zero("after_reset");
        @(posedge clk); #1;

        // MEM_LATENCY=1: CPU write then read of 0x3000, then a cross-port pattern
        timed(0, 1'b0, 1'b1, 16'h3000, 16'h1234);
        timed(0, 1'b0, 1'b0, 16'h3000, 16'h0000);
        access(0, 1'b1, 1'b1, 16'h0077, 16'hA5A5);
        access(0, 1'b0, 1'b0, 16'h0077, 16'h0000);

        // MEM_LATENCY=4: debug write then timed debug read of 0x0010
        access(1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        timed(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        check_val("dbg_rdata_hold", {16'd0, dbg_rdata[1]}, 32'h0000BEEF);

        // Simultaneous requests on instance 0: 3 CPU writes vs 2 debug reads
        access(0, 1'b1, 1'b1, 16'h0050, 16'h5A5A);
        ci = 0;
        di = 0;
        while (ci < 3 || di < 2) begin
            if (ci < 3 && di < 2) begin
`ifdef LC3_MEM_ARB_ROUNDROBIN_EN
                win = ptr_model[0];
`else
                win = 1'b0;
`endif
            end else begin
                win = (ci >= 3);
            end
            if (win) begin
                push(0, 1'b1, 1'b0, 16'h0050, 16'h0000);
                di++;
            end else begin
                push(0, 1'b0, 1'b1, 16'(32'h40 + ci), 16'(32'h1000 + ci));
                ci++;
            end
        end
        fork
            begin
                for (int i = 0; i < 3; i++) drive(0, 1'b0, 1'b1, 16'(32'h40 + i), 16'(32'h1000 + i));
            end
            begin
                for (int i = 0; i < 2; i++) drive(0, 1'b1, 1'b0, 16'h0050, 16'h0000);
            end
        join
        access(0, 1'b1, 1'b0, 16'h0041, 16'h0000);

        // MEM_LATENCY=3: reset during WAIT of a CPU read aborts it silently
        access(2, 1'b0, 1'b1, 16'h0020, 16'h0042);
        access(2, 1'b0, 1'b0, 16'h0020, 16'h0000);
        set_req(2, 1'b0, 1'b0, 16'h0020, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        check_val("rst_busy", {31'd0, busy[2]}, 32'd0);
        check_val("rst_cpu_rdata", {16'd0, cpu_rdata[2]}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cpu_req[2]   = 1'b0;
        rst_n[2]     = 1'b1;
        ptr_model[2] = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_ack[2] === 1'b1 || dbg_ack[2] === 1'b1 || busy[2] === 1'b1) acks++;
        end
        check_val("post_reset_quiet", acks, 32'd0);
        check_val("post_reset_rdata", {16'd0, cpu_rdata[2]}, 32'd0);
        check_val("post_reset_owner", {31'd0, owner[2]}, 32'd0);
        @(posedge clk); #1;
        access(2, 1'b0, 1'b0, 16'h0020, 16'h0000);

        repeat (4) @(negedge clk);
        for (int g = 0; g < NI; g++) check_val($sformatf("sb_empty[%0d]", g), exp_q[g].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Sequences the single-port unified LC-3 memory and shares it between two requesters: the CPU memory interface (MAR/MDR path, driven by the control FSM) and a debug/loader port used by the system benches to load programs and dump memory.
- Owns memory access timing and returns the LC-3 ready signal (R) to the CPU as `cpu_ack`.
- Sits between `lc3` top-level control and the memory array.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LATENCY, 1, cycles from the `mem_en` cycle to valid `mem_rdata`. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access request, held until `cpu_ack`
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  CPU address (MAR)
- cpu_wdata  input  DATA_W  CPU write data (MDR)
- cpu_rdata  output  DATA_W  read data to MDR, valid while `cpu_ack`=1
- cpu_ack  output  1  one-cycle completion pulse (LC-3 R)
- dbg_req  input  1  debug request, held until `dbg_ack`
- dbg_we  input  1  debug write enable
- dbg_addr  input  ADDR_W  debug address
- dbg_wdata  input  DATA_W  debug write data
- dbg_rdata  output  DATA_W  debug read data, valid while `dbg_ack`=1
- dbg_ack  output  1  one-cycle completion pulse
- mem_en  output  1  one-cycle memory strobe
- mem_we  output  1  memory write enable, qualified by `mem_en`
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  1 in any state other than IDLE
- owner  output  1  current/last grant: 0 = CPU, 1 = debug

Behaviour:
- Reset (async, `reset_n`=0): state IDLE; all outputs 0, including rdata registers, `owner`, `cnt`, and the round-robin pointer. Reset mid-access aborts the access silently: no ack is issued after reset is released.
- All outputs are registered.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any request is high, grant one requester and latch its we/addr/wdata into the `mem_*` registers.
  - Set `owner` and go to ACCESS.
  - If no request, stay in IDLE.
- ACCESS (1 cycle):
  - `mem_en`=1 and `mem_we`=latched we.
  - Load `cnt` = MEM_LATENCY-1, go to WAIT.
- WAIT:
  - `mem_en`=0; `mem_addr`, `mem_we` and `mem_wdata` hold their values.
  - While `cnt`≠0, decrement.
  - When `cnt`=0, `mem_rdata` is valid this cycle. Capture it into the owner's rdata register (reads only; writes leave rdata unchanged) and go to RESP.
- RESP (1 cycle):
  - Owner's ack=1. Rdata is held until the next capture for that requester.
  - Go to IDLE.
- Latency: request first high in IDLE cycle t gives `mem_en` at t+1 and ack at t+MEM_LATENCY+2. Writes use identical timing.
- Handshake rules:
  - The requester keeps req, we, addr and wdata stable from req assertion until it samples ack=1.
  - The requester deasserts req (or presents a new request) in the cycle after ack.
  - Back-to-back accesses cost one IDLE cycle.
- Req dropped mid-access: ignored; the access completes and ack still pulses.
- Req input changes during ACCESS/WAIT/RESP: not sampled.
- Simultaneous requests in IDLE: arbitration policy per Optional Feature. The loser waits with its req held and is granted on the next IDLE.
- Both acks are never high in the same cycle.
- `busy`=0 only in IDLE.

Optional Feature:
- Macro: LC3_MEM_ARB_ROUNDROBIN_EN.
- Defined:
  - Round-robin arbitration using a 1-bit pointer that names the preferred requester.
  - On a tie, the preferred requester wins.
  - After each grant, the pointer moves to the other requester.
  - The pointer resets to CPU.
- Undefined:
  - Fixed priority: CPU always wins a tie.
  - The debug port is served only when `cpu_req`=0 in IDLE.

Test Plan:
- Reset then idle: `reset_n` low 2 cycles, then high → all outputs 0, `busy`=0, no `mem_en` for 10 cycles.
- CPU write then read, MEM_LATENCY=1:
  - `cpu_req`=1, `cpu_we`=1, addr 0x3000, wdata 0x1234 at cycle t → `mem_en`=1 at t+1 with `mem_we`=1, `mem_addr`=0x3000, `mem_wdata`=0x1234; `cpu_ack` at t+3 only.
  - Read of 0x3000 with the memory model returning 0x1234 → `cpu_rdata`=0x1234 while `cpu_ack`=1.
- Latency sweep: MEM_LATENCY=4, debug read of 0x0010 returning 0xBEEF → `dbg_ack` exactly 6 cycles after req; `dbg_rdata`=0xBEEF; `cpu_ack` stays 0.
- Simultaneous requests, macro undefined: both reqs held for 3 accesses → grants CPU, CPU, CPU; debug is granted only after `cpu_req` drops.
- Simultaneous requests, LC3_MEM_ARB_ROUNDROBIN_EN defined: both reqs held → grant order CPU, debug, CPU, debug; `owner` toggles 0,1,0,1.
- Reset mid-operation: `reset_n` low during WAIT of a CPU read, MEM_LATENCY=3 → no `cpu_ack` after release, state IDLE, `cpu_rdata`=0; a fresh request then completes normally.
